// File: rtl/muldiv_sequencer.sv
// Mul/div latency sequencer: issues the unit start, times the operation,
// pulses the HI/LO write at completion and stalls HI/LO hazards in ID.
module muldiv_sequencer #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic ID_MulDivStart,
    input  logic ID_IsDiv,
    input  logic ID_Signed,
    input  logic ID_DivZero,
    input  logic ID_ReadsHiLo,
    input  logic ID_WritesHiLo,
    input  logic Flush,
    output logic Unit_Start,
    output logic Unit_IsDiv,
    output logic Unit_Signed,
    output logic HiLo_Write,
    output logic Busy,
    output logic PCWrite,
    output logic IF_ID_Write,
    output logic ControlMux
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             op_div;
    logic             op_signed;
    logic             dz;
    logic             accept;
    logic             accept_dz;
    logic             stall;

    assign accept    = (state == S_IDLE) & ID_MulDivStart & ~Flush;
    assign accept_dz = ID_IsDiv & ID_DivZero;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
            dz        <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_div    <= ID_IsDiv;
                        op_signed <= ID_Signed;
                        dz        <= accept_dz;
                        // A zero divisor skips the iteration and only marks time
                        if (accept_dz)
                            cnt <= '0;
                        else if (ID_IsDiv)
                            cnt <= DIV_LOAD;
                        else
                            cnt <= MUL_LOAD;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt == '0)
                        state <= S_DONE;
                    else
                        cnt <= cnt - 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Gated by reset so no start leaks out while the sequencer is held
    assign Unit_Start  = accept & Rst_n;
    assign Unit_IsDiv  = op_div;
    assign Unit_Signed = op_signed;
    assign Busy        = (state != S_IDLE);
    assign HiLo_Write  = (state == S_DONE) & ~dz;

    assign stall = Busy & ~Flush &
                   (ID_ReadsHiLo | ID_WritesHiLo | ID_MulDivStart);

    assign PCWrite     = ~stall;
    assign IF_ID_Write = ~stall;
    assign ControlMux  = ~stall;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed scenarios then random traffic,
// checked every cycle against a remaining-busy-cycles reference model.
module tb_muldiv_sequencer;

    localparam int MULT_CYCLES = 4;
    localparam int DIV_CYCLES  = 32;

    logic Clk = 1'b0;
    logic Rst_n;
    logic ID_MulDivStart, ID_IsDiv, ID_Signed, ID_DivZero;
    logic ID_ReadsHiLo, ID_WritesHiLo, Flush;
    logic Unit_Start, Unit_IsDiv, Unit_Signed, HiLo_Write, Busy;
    logic PCWrite, IF_ID_Write, ControlMux;

    muldiv_sequencer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (6)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .ID_MulDivStart(ID_MulDivStart),
        .ID_IsDiv      (ID_IsDiv),
        .ID_Signed     (ID_Signed),
        .ID_DivZero    (ID_DivZero),
        .ID_ReadsHiLo  (ID_ReadsHiLo),
        .ID_WritesHiLo (ID_WritesHiLo),
        .Flush         (Flush),
        .Unit_Start    (Unit_Start),
        .Unit_IsDiv    (Unit_IsDiv),
        .Unit_Signed   (Unit_Signed),
        .HiLo_Write    (HiLo_Write),
        .Busy          (Busy),
        .PCWrite       (PCWrite),
        .IF_ID_Write   (IF_ID_Write),
        .ControlMux    (ControlMux)
    );

    always #5 Clk = ~Clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: busy cycles still to come for the op in flight
    int m_left = 0;
    bit m_dz   = 0;
    bit m_div  = 0;
    bit m_sgn  = 0;

    int cyc, hl_cnt, hl_at, us_at;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic st, input logic dv, input logic sg,
                          input logic z, input logic rd, input logic wr,
                          input logic fl);
        ID_MulDivStart = st;
        ID_IsDiv       = dv;
        ID_Signed      = sg;
        ID_DivZero     = z;
        ID_ReadsHiLo   = rd;
        ID_WritesHiLo  = wr;
        Flush          = fl;
    endtask

    task automatic new_test();
        cyc    = 0;
        hl_cnt = 0;
        hl_at  = -1;
        us_at  = -1;
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge
    task automatic cycle();
        bit e_acc, e_busy, e_hl, e_stall;
        @(negedge Clk);
        if (!Rst_n) begin
            m_left = 0;
            m_dz   = 0;
            m_div  = 0;
            m_sgn  = 0;
        end
        e_acc   = Rst_n && m_left == 0 && ID_MulDivStart && !Flush;
        e_busy  = m_left > 0;
        e_hl    = m_left == 1 && !m_dz;
        e_stall = e_busy && !Flush &&
                  (ID_ReadsHiLo || ID_WritesHiLo || ID_MulDivStart);
        chk("unit_start", Unit_Start, e_acc);
        chk("busy", Busy, e_busy);
        chk("hilo_write", HiLo_Write, e_hl);
        chk("pcwrite", PCWrite, !e_stall);
        chk("if_id_write", IF_ID_Write, !e_stall);
        chk("controlmux", ControlMux, !e_stall);
        chk("unit_isdiv", Unit_IsDiv, m_div);
        chk("unit_signed", Unit_Signed, m_sgn);
        if (HiLo_Write) begin
            hl_cnt++;
            hl_at = cyc;
        end
        if (Unit_Start) us_at = cyc;
        @(posedge Clk);
        if (Rst_n) begin
            if (m_left > 0) begin
                m_left--;
            end else if (e_acc) begin
                m_div  = ID_IsDiv;
                m_sgn  = ID_Signed;
                m_dz   = ID_IsDiv && ID_DivZero;
                m_left = (m_dz ? 1 : (ID_IsDiv ? DIV_CYCLES : MULT_CYCLES)) + 1;
            end
        end
        #1;
        cyc++;
    endtask

    initial begin
        Rst_n = 1'b0;
        set_in(1, 1, 1, 0, 1, 1, 0);
        new_test();
        #2;
        cycle();
        cycle();
        #1 Rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // MULT: HI/LO written at cycle 5 only
        new_test();
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (7) cycle();
        chk_int("mult_hl_at", hl_at, 5);
        chk_int("mult_hl_cnt", hl_cnt, 1);

        // DIV with MFLO waiting in ID from cycle 2
        new_test();
        set_in(1, 1, 1, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 1, 0, 0);
        repeat (33) cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk_int("div_hl_at", hl_at, 33);

        // Back-to-back MULT held in ID until the first completes
        new_test();
        set_in(1, 0, 1, 0, 0, 0, 0);
        cycle();
        set_in(1, 0, 0, 0, 0, 0, 0);
        repeat (6) cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (7) cycle();
        chk_int("b2b_start_at", us_at, 6);
        chk_int("b2b_hl_at", hl_at, 11);
        chk_int("b2b_hl_cnt", hl_cnt, 2);

        // Divide by zero: short op, no write, next MULT at cycle 3
        new_test();
        set_in(1, 1, 0, 1, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle();
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk_int("dz_next_start", us_at, 3);
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (6) cycle();
        chk_int("dz_hl_at", hl_at, 8);
        chk_int("dz_hl_cnt", hl_cnt, 1);

        // Flush blocks a start in IDLE and masks a stall during RUN
        new_test();
        set_in(1, 1, 0, 0, 0, 0, 1);
        cycle();
        set_in(0, 0, 0, 0, 1, 1, 1);
        cycle();
        chk_int("flush_no_start", us_at, -1);
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 1, 0, 1);
        cycle();
        set_in(0, 0, 0, 0, 1, 0, 0);
        repeat (5) cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Reset mid-DIV abandons the op without a write
        new_test();
        set_in(1, 1, 0, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 1, 0, 0);
        repeat (2) cycle();
        Rst_n = 1'b0;
        cycle();
        Rst_n = 1'b1;
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (40) cycle();
        chk_int("rst_hl_cnt", hl_cnt, 1);
        chk_int("rst_hl_at", hl_at, 9);

        // Random traffic
        new_test();
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom % 4) == 0, $urandom % 2, $urandom % 2,
                   ($urandom % 4) == 0, ($urandom % 3) == 0,
                   ($urandom % 5) == 0, ($urandom % 6) == 0);
            Rst_n = ($urandom % 300) != 0;
            cycle();
        end
        Rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (40) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
